// File: rtl/sm4_pkg.sv
// Shared definitions for the iterative SM4 round controller: FSM encoding,
// default geometry and the rotation amounts of the data-path linear transform L.
package sm4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sm4_state_e;

  localparam int SM4_ROUNDS = 32;
  localparam int SM4_RK_AW  = 5;

  localparam int ROT_A = 2;
  localparam int ROT_B = 10;
  localparam int ROT_C = 18;
  localparam int ROT_D = 24;

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

endpackage

// File: rtl/sm4_t_transform.sv
// Combinational SM4 round function T: four parallel S-box lookups followed by
// the linear transform L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24.
module sm4_t_transform
  import sm4_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  logic [31:0] sub;

  always_comb begin
    sub  = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};
    dout = sub ^ rotl32(sub, ROT_A) ^ rotl32(sub, ROT_B) ^ rotl32(sub, ROT_C) ^ rotl32(sub, ROT_D);
  end

endmodule

// File: rtl/sm4_round_ctrl.sv
// Iterative SM4 engine: one shared T-transform stepped through ROUNDS rounds,
// round keys fetched from an external same-cycle store in enc or dec order.
module sm4_round_ctrl
  import sm4_pkg::*;
#(
  parameter int ROUNDS = SM4_ROUNDS,
  parameter int RK_AW  = SM4_RK_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  input  logic               in_decrypt,
  output logic [RK_AW-1:0]   rk_addr,
  input  logic [31:0]        rk_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic               busy
);

  localparam logic [RK_AW-1:0] LAST = RK_AW'(ROUNDS - 1);

  sm4_state_e       state_q, state_d;
  logic [RK_AW-1:0] cnt_q;
  logic             mode_q;
  logic [31:0]      x0_q, x1_q, x2_q, x3_q;
  logic [31:0]      t_in, t_out, x_new;

  assign t_in  = x1_q ^ x2_q ^ x3_q ^ rk_data;
  assign x_new = x0_q ^ t_out;

  sm4_t_transform u_t (
    .din  (t_in),
    .dout (t_out)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_addr   = '0;
    out_data  = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        rk_addr = mode_q ? (LAST - cnt_q) : cnt_q;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = {x3_q, x2_q, x1_q, x0_q};
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counter wraps back to 0 on its own when the final round retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
      x0_q   <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      x3_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x0_q   <= in_data[127:96];
            x1_q   <= in_data[95:64];
            x2_q   <= in_data[63:32];
            x3_q   <= in_data[31:0];
            mode_q <= in_decrypt;
            cnt_q  <= '0;
          end
        end
        RUN: begin
          x0_q  <= x1_q;
          x1_q  <= x2_q;
          x2_q  <= x3_q;
          x3_q  <= x_new;
          cnt_q <= cnt_q + RK_AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// Directed self-checking bench for sm4_round_ctrl; carries its own SM4 key
// schedule and block reference model to drive the round-key store and predict results.
`timescale 1ns/1ps
module tb_sm4_round_ctrl;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_decrypt = 1'b0;
  logic [4:0]   rk_addr;
  logic [31:0]  rk_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  logic [31:0]  rk_table [32];
  logic         rk_override = 1'b0;
  logic [31:0]  rk_junk = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int present_cyc = 0;
  int lat = 0;
  int n = 0;

  int           accept_log [$];
  int           rk_log [$];
  logic [127:0] out_log [$];

  logic [127:0] blk [4];
  logic         blk_dec [4];

  sm4_round_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_decrypt (in_decrypt),
    .rk_addr    (rk_addr),
    .rk_data    (rk_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural round-key store with a same-cycle read.
  always_comb rk_data = rk_override ? rk_junk : rk_table[rk_addr];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (in_valid && in_ready) accept_log.push_back(cyc);
    if (busy && !out_valid) rk_log.push_back(int'(rk_addr));
    if (out_valid && out_ready) out_log.push_back(out_data);
  end

  function automatic logic [31:0] rotl(input logic [31:0] v, input int k);
    return (v << k) | (v >> (32 - k));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [31:0] t_data(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  task automatic expandKey(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] ck;
    k[0] = mk[127:96] ^ 32'ha3b1bac6;
    k[1] = mk[95:64]  ^ 32'h56aa3350;
    k[2] = mk[63:32]  ^ 32'h677d9197;
    k[3] = mk[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
      k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      rk_table[i] = k[i+4];
    end
  endtask

  function automatic logic [127:0] sm4Model(input logic [127:0] b, input logic dec);
    logic [31:0] x [36];
    x[0] = b[127:96]; x[1] = b[95:64]; x[2] = b[63:32]; x[3] = b[31:0];
    for (int i = 0; i < 32; i++)
      x[i+4] = x[i] ^ t_data(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? rk_table[31-i] : rk_table[i]));
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents a block right after a clock edge and returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [127:0] data, input logic dec);
    int w;
    @(posedge clk); #1;
    present_cyc = cyc;
    in_valid = 1'b1;
    in_data = data;
    in_decrypt = dec;
    w = 0;
    while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
    if (!in_ready) checkOutput("accept_timeout", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_decrypt = 1'($urandom_range(1));
  endtask

  task automatic waitOutValid();
    int w;
    w = 0;
    while (!out_valid && w < 200) begin @(posedge clk); #1; w++; end
    if (!out_valid) checkOutput("out_valid_timeout", 128'(out_valid), 128'(1));
    lat = cyc - present_cyc;
  endtask

  initial begin
    expandKey(KEY);
    #12;
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_rk_addr", 128'(rk_addr), 128'(0));
    checkOutput("rst_out_data", out_data, 128'(0));
    checkOutput("rk0", 128'(rk_table[0]), 128'(32'hf12186f9));
    checkOutput("rk31", 128'(rk_table[31]), 128'(32'h9124a012));
    rst_n = 1'b1;

    // Encrypt the standard vector; latency counted from the edge opening the accepting IDLE cycle.
    applyStimulus(PT, 1'b0);
    waitOutValid();
    checkOutput("enc_latency", 128'(lat), 128'(33));
    checkOutput("enc_data", out_data, CT);

    // Hold the result under backpressure while a new block is offered.
    in_valid = 1'b1;
    in_data = 128'hcafef00dcafef00dcafef00dcafef00d;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_data", out_data, CT);
      checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_out_valid", 128'(out_valid), 128'(0));
    checkOutput("release_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    checkOutput("release_busy", 128'(busy), 128'(0));

    // Decrypt walks the key store from the top address down.
    rk_log.delete();
    applyStimulus(CT, 1'b1);
    waitOutValid();
    checkOutput("dec_data", out_data, PT);
    checkOutput("dec_rk_count", 128'(rk_log.size()), 128'(32));
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("dec_rk_addr_%0d", i), 128'(rk_log[i]), 128'(31 - i));

    // Back-to-back blocks with both handshakes held high.
    blk[0] = PT;                                        blk_dec[0] = 1'b0;
    blk[1] = 128'h00112233445566778899aabbccddeeff;     blk_dec[1] = 1'b1;
    blk[2] = 128'hffffffff00000000a5a5a5a55a5a5a5a;     blk_dec[2] = 1'b0;
    blk[3] = 128'hdeadbeef0badf00d1234567890abcdef;     blk_dec[3] = 1'b1;
    @(posedge clk); #1;
    accept_log.delete();
    out_log.delete();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data = blk[k];
      in_decrypt = blk_dec[k];
      n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (out_log.size() < 4 && n < 300) begin @(posedge clk); #1; n++; end
    checkOutput("b2b_accepts", 128'(accept_log.size()), 128'(4));
    for (int k = 1; k < 4; k++)
      checkOutput($sformatf("b2b_gap_%0d", k), 128'(accept_log[k] - accept_log[k-1]), 128'(34));
    checkOutput("b2b_results", 128'(out_log.size()), 128'(4));
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("b2b_data_%0d", k), out_log[k], sm4Model(blk[k], blk_dec[k]));

    // Reset in the middle of round 15 throws the block away.
    applyStimulus(blk[3], 1'b0);
    repeat (15) begin @(posedge clk); #1; end
    checkOutput("mid_rk_addr", 128'(rk_addr), 128'(15));
    out_log.delete();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("mid_rst_in_ready", 128'(in_ready), 128'(1));
    checkOutput("mid_rst_busy", 128'(busy), 128'(0));
    #3;
    rst_n = 1'b1;
    applyStimulus(PT, 1'b0);
    waitOutValid();
    checkOutput("post_rst_data", out_data, CT);
    checkOutput("post_rst_no_stale", 128'(out_log.size()), 128'(0));

    // Idle with noisy key bus and mode input.
    @(posedge clk); #1;
    rk_override = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rk_junk = $urandom;
      in_decrypt = ~in_decrypt;
      @(posedge clk); #1;
      checkOutput("idle_busy", 128'(busy), 128'(0));
      checkOutput("idle_rk_addr", 128'(rk_addr), 128'(0));
      checkOutput("idle_in_ready", 128'(in_ready), 128'(1));
    end
    rk_override = 1'b0;
    applyStimulus(blk[2], 1'b0);
    waitOutValid();
    checkOutput("idle_then_enc", out_data, sm4Model(blk[2], 1'b0));

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
